master_vldrdy: RTL

Valid/ready stream source: the transmitting end of the `slave_vldrdy` sink protocol. Words pushed in through a load port are buffered in a small FIFO. They are presented downstream on `dst_val`/`dst_rdy`/`dst_data`, with optional pseudo-random valid gaps for backpressure testing. The block also counts delivered words on `read_counter`, which feeds the sink's `read_counter` input to end the run.

---
 rtl/master_vldrdy.sv | 134 +++++++++++++
 1 files changed

// File: rtl/master_vldrdy.sv
// rtl/master_vldrdy.sv - valid/ready stream source with load FIFO and LFSR throttle
// Words loaded on ld_* are buffered and offered on dst_*; read_counter counts deliveries.
module master_vldrdy #(
    parameter int          DWIDTH    = 8,
    parameter int          DEPTH     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic              cfg_throttle,
    input  logic              ld_val,
    output logic              ld_rdy,
    input  logic [DWIDTH-1:0] ld_data,
    output logic              dst_val,
    input  logic              dst_rdy,
    output logic [DWIDTH-1:0] dst_data,
    output logic [9:0]        read_counter
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [15:0]       r_lfsr;
    logic [9:0]        r_read_counter;
    state_t            r_state;

    state_t            w_state_next;
    logic              w_dst_val;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_go;
    logic              w_lfsr_fb;
    logic [AW:0]       w_count_next;

    assign w_full    = (r_count == FULL_CNT);
    assign w_push    = ld_val && ld_rdy;
    assign w_pop     = w_dst_val && dst_rdy && (r_count != '0);
    assign w_go      = !cfg_throttle || r_lfsr[0];
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // No bypass: a full FIFO refuses loads even when a pop is pending.
    assign ld_rdy       = rst_n && cfg_en && !w_full;
    assign dst_val      = w_dst_val;
    assign dst_data     = rst_n ? r_mem[r_rd_ptr] : '0;
    assign read_counter = rst_n ? r_read_counter : '0;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!cfg_en) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((r_count != '0) && w_go) begin
                        w_state_next = S_OFFER;
                    end
                end
                S_OFFER: begin
                    // The offered word is held until it is taken; only then may a gap be inserted.
                    if (w_pop) begin
                        w_state_next = ((w_count_next != '0) && w_go) ? S_OFFER : S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_dst_val = 1'b0;
        if (rst_n && cfg_en && (r_state == S_OFFER)) begin
            w_dst_val = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_read_counter <= '0;
            r_lfsr         <= SEED;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= ld_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr       <= r_rd_ptr + PTR_ONE;
                r_read_counter <= r_read_counter + 10'd1;
            end
            r_count <= w_count_next;
            // The LFSR free-runs while enabled so gap positions do not depend on throttle history.
            if (cfg_en) begin
                r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            end
        end
    end

endmodule
